// File: rtl/seq_binary_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with a
// start/busy/done handshake, optional signed-magnitude input and overflow saturation.
module seq_binary_to_bcd #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      number_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  negative,
  output logic                  overflow
);

  localparam int                CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     CNT_LOAD  = CW'(WIDTH);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0]  MAG_ONE   = WIDTH'(1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic              IS_SIGNED = (SIGNED != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [4*DIGITS-1:0]   dig_q, dig_d;
  logic [4*DIGITS-1:0]   adj_s;
  logic                  acc_q, acc_d;
  logic                  sign_q, sign_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  neg_q, neg_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  function automatic logic [3:0] add3(input logic [3:0] d);
    if (d >= 4'd5) begin
      add3 = d + 4'd3;
    end else begin
      add3 = d;
    end
  endfunction

  // Pre-shift correction of every working digit
  always_comb begin
    adj_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj_s[4*i +: 4] = add3(dig_q[4*i +: 4]);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    dig_d   = dig_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          sign_d  = IS_SIGNED & number_in[WIDTH-1];
          if (IS_SIGNED & number_in[WIDTH-1]) begin
            mag_d = ~number_in + MAG_ONE;
          end else begin
            mag_d = number_in;
          end
          dig_d = '0;
          acc_d = 1'b0;
          cnt_d = CNT_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // The top digit's MSB is dropped here and only survives in the sticky accumulator
        {dig_d, mag_d} = {adj_s[4*DIGITS-2:0], mag_q, 1'b0};
        acc_d          = acc_q | adj_s[4*DIGITS-1];
        cnt_d          = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          neg_d   = sign_q;
          ovf_d   = acc_d;
          if (acc_d) begin
            bcd_d = ALL_NINES;
          end else begin
            bcd_d = dig_d;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      dig_q   <= '0;
      acc_q   <= 1'b0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      dig_q   <= dig_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign negative = neg_q;
  assign overflow = ovf_q;

endmodule
